// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU pipeline issuer: opcodes, instruction layout,
// in-flight tracking slot and the golden-result function.
package alu_pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Instruction word is {a[2:0], b[2:0], op[1:0]}
  localparam int INSTR_A_LSB  = 5;
  localparam int INSTR_B_LSB  = 2;
  localparam int INSTR_OP_LSB = 0;

  localparam int PKG_TAG_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [PKG_TAG_W-1:0] tag;
    logic [7:0]           expected;
  } slot_t;

  function automatic logic [7:0] encode_instr(input logic [2:0] a, input logic [2:0] b,
                                              input logic [1:0] op);
    return {a, b, op};
  endfunction

  function automatic logic [7:0] golden(input logic [2:0] a, input logic [2:0] b,
                                        input logic [1:0] op);
    logic [7:0] ax;
    logic [7:0] bx;
    logic [7:0] res;
    ax  = {5'b0, a};
    bx  = {5'b0, b};
    res = '0;
    case (op)
      OP_ADD:  res = ax + bx;
      OP_SUB:  res = ax - bx;
      OP_AND:  res = ax & bx;
      default: res = ax | bx;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_pipe_issuer_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding tagged responses; the head
// entry is visible on pop_data whenever the FIFO is not empty.
module alu_pipe_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 13,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    pop_eff  = pop && !empty;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop_eff);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/alu_pipe_issuer.sv
// Issues ALU instructions into the fixed-latency pipeline, tracks them to the
// capture edge, checks results against the golden value and queues responses.
module alu_pipe_issuer
  import alu_pipe_pkg::*;
#(
  parameter int PIPE_LAT = 5,
  parameter int DEPTH    = 8,
  parameter int TAG_W    = alu_pipe_pkg::PKG_TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_a,
  input  logic [2:0]       req_b,
  input  logic [1:0]       req_op,
  output logic [7:0]       instr_out,
  input  logic [7:0]       result_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = 8 + TAG_W + 1;

  logic [7:0]       instr_q, instr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  slot_t            slot_q [PIPE_LAT];
  slot_t            slot_d [PIPE_LAT];
  logic [CW-1:0]    total_q, total_d;

  logic          issue, push, pop;
  logic [FW-1:0] push_data, head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  slot_t         oldest;

  always_comb begin
    issue     = req_valid && req_ready;
    instr_d   = '0;
    tag_d     = tag_q;
    slot_d[0] = '0;
    if (issue) begin
      instr_d   = encode_instr(req_a, req_b, req_op);
      tag_d     = tag_q + TAG_W'(1);
      slot_d[0] = '{valid: 1'b1, tag: tag_q, expected: golden(req_a, req_b, req_op)};
    end
    // Pipeline never stalls, so the tracker shifts every cycle.
    for (int i = 1; i < PIPE_LAT; i++) slot_d[i] = slot_q[i-1];
    // A capture only moves a credit from in-flight to queued.
    total_d = total_q + CW'(issue) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0;
      tag_q   <= '0;
      total_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) slot_q[i] <= '0;
    end else begin
      instr_q <= instr_d;
      tag_q   <= tag_d;
      total_q <= total_d;
      for (int i = 0; i < PIPE_LAT; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign oldest    = slot_q[PIPE_LAT-1];
  assign push      = oldest.valid;
  assign push_data = {result_in, oldest.tag, (result_in != oldest.expected)};
  assign pop       = rsp_valid && rsp_ready;

  alu_pipe_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (FW),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && fifo_full)) else $error("rsp fifo push while full");
      assert (fifo_count <= total_q) else $error("credit count below fifo occupancy");
    end
  end

  assign req_ready = (total_q < CW'(DEPTH));
  assign busy      = (total_q != '0);
  assign instr_out = instr_q;
  assign rsp_valid = !fifo_empty;
  assign {rsp_data, rsp_tag, rsp_err} = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_alu_pipe_issuer.sv
// Self-checking bench: behavioural 4-stage ALU pipeline plus a queue-based
// reference of expected responses, credits and instruction encoding.
module tb_alu_pipe_issuer;
  import alu_pipe_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_a = '0;
  logic [2:0]       req_b = '0;
  logic [1:0]       req_op = '0;
  logic [7:0]       instr_out;
  logic [7:0]       result_in;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic             corrupt_req = 1'b0;

  always #5 clk = ~clk;

  alu_pipe_issuer #(.PIPE_LAT(5), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .instr_out (instr_out),
    .result_in (result_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  function automatic logic [7:0] ref_alu(input logic [2:0] a, input logic [2:0] b,
                                         input logic [1:0] op);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x & y;
      default: r = x | y;
    endcase
    return 8'(r);
  endfunction

  // Behavioural pipeline: four registers behind instr_out, plus an aligned fault flag.
  logic [8:0] pipe [4];
  logic       cflag;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
      cflag <= 1'b0;
    end else begin
      cflag   <= req_valid & req_ready & corrupt_req;
      pipe[0] <= {cflag, instr_out};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign result_in = ref_alu(pipe[3][INSTR_A_LSB +: 3], pipe[3][INSTR_B_LSB +: 3],
                             pipe[3][INSTR_OP_LSB +: 2]) ^ {7'b0, pipe[3][8]};

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t             q[$];
  logic [TAG_W-1:0] tag_m = '0;
  logic [7:0]       exp_instr;
  logic [7:0]       last_data;
  logic [TAG_W-1:0] last_tag;
  logic             last_err;
  bit               accepted;
  int               n_rsp = 0;
  int               n_assert = 0;
  int               n_fail = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic cycle();
    bit   ready_m;
    exp_t e;
    @(negedge clk);
    ready_m = (q.size() < DEPTH);
    chk("req_ready", 32'(req_ready), 32'(ready_m));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (rsp_valid && q.size() == 0) chk("rsp_valid_spurious", 32'(rsp_valid), 32'd0);
    if (rsp_valid && rsp_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      last_data = rsp_data;
      last_tag  = rsp_tag;
      last_err  = rsp_err;
      n_rsp++;
    end
    accepted = req_valid && ready_m;
    if (accepted) begin
      e.data = ref_alu(req_a, req_b, req_op) ^ {7'b0, corrupt_req};
      e.tag  = tag_m;
      e.err  = corrupt_req;
      q.push_back(e);
      tag_m++;
      exp_instr = {req_a, req_b, req_op};
    end else begin
      exp_instr = 8'h00;
    end
    @(posedge clk);
    #1;
    chk("instr_out", 32'(instr_out), 32'(exp_instr));
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                      input logic c);
    req_a = a; req_b = b; req_op = op; corrupt_req = c; req_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) cycle();
    chk("send_timeout", 32'(accepted), 32'd1);
    req_valid = 1'b0;
    corrupt_req = 1'b0;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    corrupt_req = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) cycle();
    chk("drain_timeout", 32'(q.size()), 32'd0);
    cycle();
  endtask

  int base;
  int acc9;

  initial begin
    #12;
    chk("rst_instr", 32'(instr_out), 32'h00);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD 1+1
    rsp_ready = 1'b1;
    send(3'd1, 3'd1, OP_ADD, 1'b0);
    chk("t1_instr", 32'(instr_out), 32'h24);
    drain();
    chk("t1_data", 32'(last_data), 32'h02);
    chk("t1_tag", 32'(last_tag), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Back-to-back ADDs
    send(3'd1, 3'd1, OP_ADD, 1'b0);
    send(3'd2, 3'd1, OP_ADD, 1'b0);
    send(3'd3, 3'd2, OP_ADD, 1'b0);
    send(3'd4, 3'd3, OP_ADD, 1'b0);
    chk("t2_last_instr", 32'(instr_out), 32'h8C);
    drain();
    chk("t2_last_data", 32'(last_data), 32'h07);

    // SUB / AND / OR
    send(3'd1, 3'd3, OP_SUB, 1'b0);
    chk("t3_sub_instr", 32'(instr_out), 32'h2D);
    drain();
    chk("t3_sub_data", 32'(last_data), 32'hFE);
    send(3'd5, 3'd3, OP_AND, 1'b0);
    send(3'd4, 3'd2, OP_OR, 1'b0);
    drain();
    chk("t3_or_data", 32'(last_data), 32'h06);

    // Credit exhaustion with the consumer stalled
    base = n_rsp;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3'(i), 3'(7 - i), 2'(i), 1'b0);
    req_a = 3'd6; req_b = 3'd6; req_op = OP_ADD; req_valid = 1'b1;
    acc9 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (accepted) acc9++;
    end
    chk("t4_blocked", 32'(acc9), 32'd0);
    chk("t4_not_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) cycle();
    chk("t4_ninth_accept", 32'(accepted), 32'd1);
    req_valid = 1'b0;
    send(3'd7, 3'd1, OP_SUB, 1'b0);
    drain();
    chk("t4_rsp_count", 32'(n_rsp - base), 32'd10);

    // Corrupted capture in the middle of three
    send(3'd1, 3'd2, OP_ADD, 1'b0);
    send(3'd3, 3'd3, OP_ADD, 1'b1);
    send(3'd2, 3'd2, OP_OR, 1'b0);
    drain();
    chk("t5_last_err", 32'(last_err), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      req_valid   = 1'($urandom_range(0, 1));
      req_a       = 3'($urandom);
      req_b       = 3'($urandom);
      req_op      = 2'($urandom);
      corrupt_req = ($urandom_range(0, 7) == 0);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset with 3 in flight and 2 queued
    rsp_ready = 1'b0;
    send(3'd1, 3'd1, OP_ADD, 1'b0);
    send(3'd2, 3'd2, OP_ADD, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    send(3'd3, 3'd1, OP_SUB, 1'b0);
    send(3'd5, 3'd1, OP_AND, 1'b0);
    send(3'd6, 3'd1, OP_OR, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_instr", 32'(instr_out), 32'h00);
    q.delete();
    tag_m = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send(3'd2, 3'd3, OP_OR, 1'b0);
    drain();
    chk("t6_tag_after_reset", 32'(last_tag), 32'd0);
    chk("t6_data_after_reset", 32'(last_data), 32'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe_issuer.md
Name: alu_pipe_issuer

Overview:
- Initiator and response collector for the 8-bit 4-stage ALU pipeline.
- Accepts operation requests over a valid/ready handshake and encodes each into the pipeline's 8-bit instruction format {a[2:0], b[2:0], op[1:0]}.
- Tracks each issued instruction through the fixed pipeline latency, captures the pipeline result, and checks it against a golden value.
- Returns tagged results through a credit-protected response FIFO. Sits between the test/control logic and the processor's instruction/result ports.

Parameters:
PIPE_LAT, 5, rising edges from the issue edge (instr_out update) to the result_in capture edge: 1 issuer register + 4 pipeline registers.
DEPTH, 8, response FIFO entries; also the total credit limit (in-flight + queued).
TAG_W, 4, width of the wrapping issue tag.

Ports:
clk  in  1  rising-edge clock, shared with the pipeline
reset_n  in  1  one clock; reset is asynchronous and active-low
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle if valid
req_a  in  3  operand a
req_b  in  3  operand b
req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
instr_out  out  8  registered instruction to the pipeline input
result_in  in  8  pipeline result output
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer pops the head
rsp_data  out  8  captured result_in
rsp_tag  out  TAG_W  tag of the originating request
rsp_err  out  1  captured result differs from the golden value
busy  out  1  any instruction in flight or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): instr_out=0x00, tag counter=0, all in-flight slots invalid, FIFO empty, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, busy=0.
- Credits: total = in-flight count + FIFO count, range 0..DEPTH. req_ready = (total < DEPTH), decoded from registers only; no combinational path from rsp_ready.
- Issue (req_valid & req_ready at an edge):
  - instr_out <= {req_a, req_b, req_op}.
  - In-flight slot 0 <= {valid=1, tag, expected}.
  - tag <= tag+1, wrapping mod 2^TAG_W.
- No issue: instr_out <= 0x00 (NOP bubble); slot 0 <= invalid.
- Golden value: a and b zero-extended to 8 bits. ADD = a+b; SUB = (a−b) mod 256, so 1−3 = 0xFE; AND = a&b; OR = a|b.
- In-flight tracker: a PIPE_LAT-deep shift register of {valid, tag, expected[7:0]} that advances every cycle, unconditionally, because the pipeline has no stall.
- Capture: when the oldest slot is valid, at that edge push {result_in, tag, result_in != expected} into the FIFO. Invalid slots (bubbles) are ignored.
- FIFO overflow cannot occur: the credit rule guarantees space. An implementation assertion must flag a push while the FIFO is full.
- Pop: rsp_valid & rsp_ready. Push and pop in the same cycle are both performed and the count is unchanged. The head is shown first-word-fall-through on rsp_* outputs.
- Credit accounting per edge:
  - total += issue
  - total −= pop
  - A capture moves a unit from in-flight to FIFO and leaves total unchanged.
  - Issue and pop in the same cycle leave total unchanged.
- Ordering: responses appear in issue order; tags are strictly consecutive mod 2^TAG_W.
- Throughput: one issue per cycle while credits remain. Minimum request-to-rsp_valid latency is PIPE_LAT+1 edges: rsp_valid rises at the edge after capture. If FIFO output is registered, state so in the implementation; the bench keys on rsp_valid, not cycle count.
- busy = (total != 0).
- Reset mid-operation: all in-flight and queued entries are discarded immediately, with no partial responses. The pipeline's own reset (active-high, = ~reset_n at integration) clears its registers in the same cycle.
- No backpressure from the pipeline. The result_in hold time is the pipeline's responsibility.

Decomposition:
- Shared package alu_pipe_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR
  - an instruction field-position constant
  - an in-flight slot struct {valid, tag, expected}
  - a golden-result function, also reused by the bench
- One sub-module, alu_pipe_rsp_fifo: a synchronous FIFO, DEPTH×(8+TAG_W+1), with count output, full/empty flags and first-word-fall-through.

Test Plan:
1. Single request a=1,b=1,ADD -> instr_out=0x24 after the issue edge; one response rsp_data=0x02, rsp_tag=0, rsp_err=0; busy returns to 0 afterwards.
2. Back-to-back ADDs (1,1),(2,1),(3,2),(4,3), rsp_ready=1 -> instr_out sequence 0x24,0x44,0x68,0x8C on consecutive cycles; responses 0x02,0x03,0x05,0x07 with tags 0..3 on consecutive cycles.
3. SUB a=1,b=3 (instr 0x2D), then AND 5,3 and OR 4,2 -> rsp_data 0xFE, 0x01, 0x06; all rsp_err=0.
4. Hold rsp_ready=0 and present 10 requests -> req_ready deasserts after the 8th accept; 8 responses queue; after rsp_ready=1 the remaining 2 issue; tags 0..9 arrive in order with none lost or duplicated.
5. Bench corrupts result_in by XOR 0x01 during one capture -> that response has rsp_err=1; neighbouring responses have rsp_err=0.
6. Assert reset_n low while 3 are in flight and 2 are queued -> rsp_valid=0, busy=0, req_ready=1 at once; after release, the next response carries tag 0.
